// File: rtl/issue_ctrl.sv
// Dual-issue scheduler: buffers one fetched pair and issues it to the two
// decoder slots together, or split over two cycles on an intra-pair hazard.
module issue_ctrl #(
  parameter logic [31:0] NOP = 32'h00000013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        valid1_i,
  input  logic [31:0] inst0_i,
  input  logic [31:0] inst1_i,
  input  logic [31:0] pc_i,
  output logic        ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        iss0_valid_o,
  output logic [31:0] iss0_inst_o,
  output logic [31:0] iss0_pc_o,
  output logic        iss1_valid_o,
  output logic [31:0] iss1_inst_o,
  output logic [31:0] iss1_pc_o
);

  // state   | meaning
  // S_EMPTY | no instruction held
  // S_FULL  | pair held, inst0 (and inst1 unless split) on the slots
  // S_HALF  | inst0 already issued, only inst1 remains (on slot 0)
  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_HALF} state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
  endfunction

  function automatic logic is_mem(input logic [6:0] opc);
    return (opc == OPC_LOAD || opc == OPC_STORE);
  endfunction

  function automatic logic is_cf(input logic [6:0] opc);
    return (opc == OPC_JAL || opc == OPC_JALR || opc == OPC_BRANCH);
  endfunction

  state_t      state_q, state_d;
  logic [31:0] inst0_q, inst0_d;
  logic [31:0] inst1_q, inst1_d;
  logic [31:0] pc_q, pc_d;
  logic        valid1_q, valid1_d;

  logic [6:0] opc0, opc1;
  logic [4:0] rd0, rs1_1, rs2_1;
  logic       wr0, raw, split, load;
  logic [31:0] pc1;

  assign opc0  = inst0_q[6:0];
  assign opc1  = inst1_q[6:0];
  assign rd0   = inst0_q[11:7];
  assign rs1_1 = inst1_q[19:15];
  assign rs2_1 = inst1_q[24:20];
  assign pc1   = pc_q + 32'd4;

  assign wr0   = (opc0 != OPC_STORE) && (opc0 != OPC_BRANCH) && (rd0 != 5'd0);
  assign raw   = wr0 && ((uses_rs1(opc1) && rd0 == rs1_1) ||
                         (uses_rs2(opc1) && rd0 == rs2_1));
  assign split = raw || (is_mem(opc0) && is_mem(opc1)) || is_cf(opc0);

  assign ready_o = !flush_i && ((state_q == S_EMPTY) ||
                   (state_q == S_FULL && !stall_i && !(valid1_q && split)) ||
                   (state_q == S_HALF && !stall_i));
  assign load = valid_i && ready_o;

  always_comb begin
    state_d  = state_q;
    inst0_d  = inst0_q;
    inst1_d  = inst1_q;
    pc_d     = pc_q;
    valid1_d = valid1_q;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (valid_i) state_d = S_FULL;
        S_FULL: begin
          if (!stall_i) begin
            if (valid1_q && split) state_d = S_HALF;
            else                   state_d = valid_i ? S_FULL : S_EMPTY;
          end
        end
        S_HALF:  if (!stall_i) state_d = valid_i ? S_FULL : S_EMPTY;
        default: state_d = S_EMPTY;
      endcase
    end
    if (load) begin
      inst0_d  = inst0_i;
      inst1_d  = inst1_i;
      pc_d     = pc_i;
      valid1_d = valid1_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_EMPTY;
      inst0_q  <= '0;
      inst1_q  <= '0;
      pc_q     <= '0;
      valid1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      inst0_q  <= inst0_d;
      inst1_q  <= inst1_d;
      pc_q     <= pc_d;
      valid1_q <= valid1_d;
    end
  end

  // In HALF the younger instruction moves down to slot 0 to keep program order.
  always_comb begin
    iss0_valid_o = 1'b0;
    iss0_inst_o  = NOP;
    iss0_pc_o    = '0;
    iss1_valid_o = 1'b0;
    iss1_inst_o  = NOP;
    iss1_pc_o    = '0;
    case (state_q)
      S_FULL: begin
        iss0_valid_o = 1'b1;
        iss0_inst_o  = inst0_q;
        iss0_pc_o    = pc_q;
        if (valid1_q && !split) begin
          iss1_valid_o = 1'b1;
          iss1_inst_o  = inst1_q;
          iss1_pc_o    = pc1;
        end
      end
      S_HALF: begin
        iss0_valid_o = 1'b1;
        iss0_inst_o  = inst1_q;
        iss0_pc_o    = pc1;
      end
      default: ;
    endcase
  end

endmodule
